nn_neuron_mac: RTL and testbench

- Parametrised, handshaked successor of the single-neuron MAC used in the DQN inference datapath.
- Accumulates a bias plus a variable-length stream of input×weight products for one neuron.
- Rescales the sum to the fixed-point activation format, with round-to-nearest and saturation, and presents it on a valid/ready output.
- Sits between the layer sequencer (which streams activations and weights) and the activation/output buffer.

---
 rtl/nn_pkg.sv | 45 ++++
 rtl/nn_neuron_mac_if.sv | 29 ++
 rtl/nn_round_sat.sv | 34 +++
 rtl/nn_neuron_mac.sv | 133 +++++++++++++
 tb/tb_nn_neuron_mac.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types, default widths and the rescale/round/saturate helper
// for the neuron MAC datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAC_BITS = 10;
    localparam int RES_W         = 32;

    typedef struct packed {
        logic signed [RES_W-1:0] value;
        logic                    sat;
    } sat_res_t;

    // Round half up at the binary point, then clip to a data_w-bit signed range.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int data_w,
                                           input int frac_bits);
        sat_res_t          res;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (r > max_v) begin
            res.value = max_v[RES_W-1:0];
            res.sat   = 1'b1;
        end else if (r < min_v) begin
            res.value = min_v[RES_W-1:0];
            res.sat   = 1'b1;
        end else begin
            res.value = r[RES_W-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/nn_neuron_mac_if.sv
// Handshake bundle between the layer sequencer (master) and one neuron MAC (slave).
interface nn_neuron_mac_if #(
    parameter int DATA_W = nn_pkg::DEF_DATA_W,
    parameter int BIAS_W = 32
);
    logic                     start;
    logic signed [BIAS_W-1:0] bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_w;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     out_len_err;
    logic                     busy;

    modport master (
        output start, bias, in_valid, in_data, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_len_err, busy
    );

    modport slave (
        input  start, bias, in_valid, in_data, in_w, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_len_err, busy
    );
endinterface

// File: rtl/nn_round_sat.sv
// Combinational rescale of an accumulator to the activation format with
// round-half-up and saturation; NN_NEURON_MAC_RELU_EN adds a ReLU clamp after saturation.
module nn_round_sat
    import nn_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] data,
    output logic                     sat
);
    sat_res_t                res_s;
    logic [RES_W-DATA_W-1:0] unused_hi_s;

    // Rescale through the shared helper; the ReLU clamp leaves the sat flag untouched.
    always_comb begin
        res_s = sat_round(64'(acc), DATA_W, FRAC_BITS);
        sat   = res_s.sat;
`ifdef NN_NEURON_MAC_RELU_EN
        if (res_s.value[DATA_W-1]) begin
            data = '0;
        end else begin
            data = res_s.value[DATA_W-1:0];
        end
`else
        data  = res_s.value[DATA_W-1:0];
`endif
    end

    assign unused_hi_s = res_s.value[RES_W-1:DATA_W];

endmodule

// File: rtl/nn_neuron_mac.sv
// Handshaked single-neuron MAC: acc = bias + sum(in_data*in_w), rescaled to DATA_W.
// Build option: NN_NEURON_MAC_RELU_EN applies ReLU in the output stage.
module nn_neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = 40,
    parameter int BIAS_W    = 32,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int MAX_LEN   = 256
) (
    input logic            clk,
    input logic            rst,
    nn_neuron_mac_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(MAX_LEN + 1);

    generate
        if ((ACC_W < PROD_W + $clog2(MAX_LEN)) || (ACC_W < BIAS_W) || (ACC_W >= 64) ||
            (DATA_W >= RES_W) || (FRAC_BITS < 1) || (MAX_LEN < 1)) begin : g_bad_cfg
            $error("nn_neuron_mac: ACC_W too small for DATA_W/MAX_LEN/BIAS_W, or parameter out of range");
        end
    endgenerate

    state_t                   state_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [PROD_W-1:0] prod_r;
    logic                     prod_vld_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     len_err_r;
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] out_data_r;
    logic                     out_sat_r;
    logic                     out_len_err_r;

    logic                     beat_s;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic signed [DATA_W-1:0] rs_data_s;
    logic                     rs_sat_s;

    assign beat_s = bus.in_valid & (state_r == ACCUM);

    // Second MAC stage: fold the registered product into the running sum.
    always_comb begin
        if (prod_vld_r) begin
            acc_next_s = acc_r + ACC_W'(prod_r);
        end else begin
            acc_next_s = acc_r;
        end
    end

    // The rounder sees the sum including the last product, so DONE needs no extra cycle.
    nn_round_sat #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc  (acc_next_s),
        .data (rs_data_s),
        .sat  (rs_sat_s)
    );

    // Neuron sequencing, two-stage MAC and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            acc_r         <= '0;
            prod_r        <= '0;
            prod_vld_r    <= 1'b0;
            cnt_r         <= '0;
            len_err_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_sat_r     <= 1'b0;
            out_len_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        acc_r      <= ACC_W'(bus.bias);
                        prod_vld_r <= 1'b0;
                        cnt_r      <= '0;
                        len_err_r  <= 1'b0;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_r <= acc_next_s;
                    if (beat_s) begin
                        prod_r     <= PROD_W'(bus.in_data) * PROD_W'(bus.in_w);
                        prod_vld_r <= 1'b1;
                        cnt_r      <= cnt_r + CNT_W'(1);
                        if (bus.in_last) begin
                            state_r <= DRAIN;
                        end else if (cnt_r == CNT_W'(MAX_LEN - 1)) begin
                            len_err_r <= 1'b1;
                            state_r   <= DRAIN;
                        end
                    end else begin
                        prod_vld_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    acc_r         <= acc_next_s;
                    prod_vld_r    <= 1'b0;
                    out_data_r    <= rs_data_s;
                    out_sat_r     <= rs_sat_s;
                    out_len_err_r <= len_err_r;
                    out_valid_r   <= 1'b1;
                    state_r       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (state_r == ACCUM);
    assign bus.busy        = (state_r != IDLE);
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_sat     = out_sat_r;
    assign bus.out_len_err = out_len_err_r;

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Scoreboard bench for nn_neuron_mac: one DUT at MAX_LEN=256, one at MAX_LEN=4,
// both checked against an arithmetic reference model.
module tb_nn_neuron_mac;
    localparam int DW = 16;
    localparam int BW = 32;
    localparam int FB = 10;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 sat;
        logic                 len_err;
    } exp_t;

    logic                 clk         = 1'b0;
    logic                 rst         = 1'b1;
    logic                 sel_s       = 1'b0;
    logic                 start_s     = 1'b0;
    logic signed [BW-1:0] bias_s      = '0;
    logic                 in_valid_s  = 1'b0;
    logic signed [DW-1:0] in_data_s   = '0;
    logic signed [DW-1:0] in_w_s      = '0;
    logic                 in_last_s   = 1'b0;
    logic                 out_ready_s = 1'b1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic signed [DW-1:0] st_d[$];
    logic signed [DW-1:0] st_w[$];

    nn_neuron_mac_if #(.DATA_W(DW), .BIAS_W(BW)) bus0 ();
    nn_neuron_mac_if #(.DATA_W(DW), .BIAS_W(BW)) bus4 ();

    assign bus0.start     = start_s & ~sel_s;
    assign bus4.start     = start_s & sel_s;
    assign bus0.bias      = bias_s;
    assign bus4.bias      = bias_s;
    assign bus0.in_valid  = in_valid_s;
    assign bus4.in_valid  = in_valid_s;
    assign bus0.in_data   = in_data_s;
    assign bus4.in_data   = in_data_s;
    assign bus0.in_w      = in_w_s;
    assign bus4.in_w      = in_w_s;
    assign bus0.in_last   = in_last_s;
    assign bus4.in_last   = in_last_s;
    assign bus0.out_ready = out_ready_s;
    assign bus4.out_ready = out_ready_s;

    nn_neuron_mac #(.DATA_W(DW), .ACC_W(40), .BIAS_W(BW), .FRAC_BITS(FB), .MAX_LEN(256)) dut (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    nn_neuron_mac #(.DATA_W(DW), .ACC_W(40), .BIAS_W(BW), .FRAC_BITS(FB), .MAX_LEN(4)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4.slave)
    );

    logic                 rdy_sel;
    logic                 vld_sel;
    logic                 busy_sel;
    logic signed [DW-1:0] data_sel;
    assign rdy_sel  = sel_s ? bus4.in_ready  : bus0.in_ready;
    assign vld_sel  = sel_s ? bus4.out_valid : bus0.out_valid;
    assign busy_sel = sel_s ? bus4.busy      : bus0.busy;
    assign data_sel = sel_s ? bus4.out_data  : bus0.out_data;

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int beats_taken(input int n, input int maxl);
        return (n > maxl) ? maxl : n;
    endfunction

    // Reference: exact integer sum, floor((sum + half) / 2^FB), clip, optional ReLU.
    function automatic exp_t model(input longint b, input int n, input bit lof, input int maxl);
        exp_t   e;
        longint sum;
        longint num;
        longint q;
        longint maxv;
        longint minv;
        int     used;
        used = beats_taken(n, maxl);
        sum  = b;
        for (int i = 0; i < used; i++) sum += longint'(st_d[i]) * longint'(st_w[i]);
        num  = sum + longint'(2 ** (FB - 1));
        q    = num / longint'(2 ** FB);
        if ((num % longint'(2 ** FB) != 0) && (num < 0)) q = q - 1;
        maxv = longint'(2 ** (DW - 1)) - 1;
        minv = -longint'(2 ** (DW - 1));
        e.sat = 1'b0;
        if (q > maxv) begin q = maxv; e.sat = 1'b1; end
        if (q < minv) begin q = minv; e.sat = 1'b1; end
        e.data = q[DW-1:0];
`ifdef NN_NEURON_MAC_RELU_EN
        if (e.data < 0) e.data = '0;
`endif
        e.len_err = (n > maxl) || ((n == maxl) && !lof);
        return e;
    endfunction

    task automatic add_beat(input logic signed [DW-1:0] d, input logic signed [DW-1:0] w);
        st_d.push_back(d);
        st_w.push_back(w);
    endtask

    task automatic clear_beats();
        st_d.delete();
        st_w.delete();
    endtask

    task automatic run_neuron(input bit sel, input longint b, input bit lof, input bit bubbles, input bit hold);
        int   n;
        int   maxl;
        int   used;
        int   sent;
        int   guard;
        bit   acc_now;
        exp_t e;
        n     = st_d.size();
        maxl  = sel ? 4 : 256;
        used  = beats_taken(n, maxl);
        e     = model(b, n, lof, maxl);
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
        sel_s   = sel;
        bias_s  = b[BW-1:0];
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < used && guard < 2000) begin
            in_valid_s = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data_s  = st_d[sent];
            in_w_s     = st_w[sent];
            in_last_s  = lof && (sent == n - 1);
            acc_now    = in_valid_s && rdy_sel;
            @(posedge clk); #1;
            if (acc_now) sent++;
            guard++;
        end
        in_valid_s = 1'b0;
        in_last_s  = 1'b0;
        check("beats_accepted", sent, used);
        check("ready_drain", rdy_sel, 0);
        check("lat_early", vld_sel, 0);
        @(posedge clk); #1;
        check("lat_valid", vld_sel, 1);
        if (!hold) begin
            guard = 0;
            while (busy_sel && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            check("return_idle", busy_sel, 0);
        end
    endtask

    // Scoreboard monitors: compare on each output handshake.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && bus0.out_valid && bus0.out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL out0_unexpected: got data %0d, expected no output", bus0.out_data);
            end else begin
                e = q0.pop_front();
                if (bus0.out_data !== e.data || bus0.out_sat !== e.sat || bus0.out_len_err !== e.len_err) begin
                    errors++;
                    $display("FAIL out0_result: got data %0d sat %0b len_err %0b, expected data %0d sat %0b len_err %0b",
                             bus0.out_data, bus0.out_sat, bus0.out_len_err, e.data, e.sat, e.len_err);
                end
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL out4_unexpected: got data %0d, expected no output", bus4.out_data);
            end else begin
                e = q1.pop_front();
                if (bus4.out_data !== e.data || bus4.out_sat !== e.sat || bus4.out_len_err !== e.len_err) begin
                    errors++;
                    $display("FAIL out4_result: got data %0d sat %0b len_err %0b, expected data %0d sat %0b len_err %0b",
                             bus4.out_data, bus4.out_sat, bus4.out_len_err, e.data, e.sat, e.len_err);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t eb;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out_data", bus0.out_data, 0);
        check("rst_out_sat", bus0.out_sat, 0);
        check("rst_len_err", bus0.out_len_err, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_in_ready", bus0.in_ready, 0);
        check("rst_busy4", bus4.busy, 0);

        clear_beats(); add_beat(16'sd1024, 16'sd2048);
        run_neuron(1'b0, 0, 1'b1, 1'b0, 1'b0);

        clear_beats();
        add_beat(16'sd1024, 16'sd1024); add_beat(-16'sd2048, 16'sd512); add_beat(16'sd512, -16'sd1024);
        run_neuron(1'b0, 1048576, 1'b1, 1'b0, 1'b0);

        clear_beats(); repeat (4) add_beat(16'sd32767, 16'sd32767);
        run_neuron(1'b0, 0, 1'b1, 1'b0, 1'b0);
        clear_beats(); repeat (4) add_beat(16'sd32767, -16'sd32768);
        run_neuron(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Backpressure: result must hold while start and stray beats are ignored.
        clear_beats(); add_beat(16'sd300, -16'sd700); add_beat(16'sd1500, 16'sd900);
        eb = model(5000, 2, 1'b1, 256);
        out_ready_s = 1'b0;
        run_neuron(1'b0, 5000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", vld_sel, 1);
            check("bp_data", data_sel, eb.data);
            check("bp_busy", busy_sel, 1);
            check("bp_ready", rdy_sel, 0);
            start_s    = (i == 2);
            bias_s     = 32'sd12345;
            in_valid_s = (i >= 1 && i <= 3);
            @(posedge clk); #1;
        end
        start_s = 1'b0; in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", vld_sel, 0);
        check("bp_release_busy", busy_sel, 0);

        // Same random neuron with and without bubbles.
        clear_beats();
        for (int i = 0; i < 20; i++) add_beat(DW'($urandom), DW'($urandom));
        run_neuron(1'b0, -777, 1'b1, 1'b0, 1'b0);
        run_neuron(1'b0, -777, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int nb;
            clear_beats();
            nb = $urandom_range(1, 24);
            for (int i = 0; i < nb; i++) add_beat(DW'($urandom), DW'($urandom));
            run_neuron(1'b0, longint'(int'($urandom)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end

        // MAX_LEN = 4 instance: length error and its boundaries.
        clear_beats(); for (int i = 0; i < 4; i++) add_beat(DW'($urandom), DW'($urandom));
        run_neuron(1'b1, 100, 1'b0, 1'b0, 1'b0);
        run_neuron(1'b1, 100, 1'b1, 1'b0, 1'b0);
        clear_beats(); for (int i = 0; i < 6; i++) add_beat(DW'($urandom), DW'($urandom));
        run_neuron(1'b1, -3000, 1'b0, 1'b1, 1'b0);
        clear_beats(); add_beat(16'sd2048, 16'sd1024); add_beat(-16'sd1024, 16'sd1024);
        run_neuron(1'b1, 0, 1'b1, 1'b0, 1'b0);

        // Reset after two accepted beats: the partial sum must vanish.
        clear_beats(); for (int i = 0; i < 3; i++) add_beat(16'sd4000, 16'sd4000);
        sel_s = 1'b0; bias_s = 32'sd777777; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_s = 1'b1; in_data_s = st_d[i]; in_w_s = st_w[i];
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", bus0.out_valid, 0);
        check("mid_rst_busy", bus0.busy, 0);
        check("mid_rst_data", bus0.out_data, 0);
        repeat (3) @(posedge clk);
        #1 check("mid_rst_no_output", bus0.out_valid, 0);
        clear_beats(); add_beat(16'sd1024, 16'sd1024);
        run_neuron(1'b0, 0, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("queue0_drained", q0.size(), 0);
        check("queue4_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
